// File: rtl/hsid_ref_fetch_ctrl_if.sv
// Reference fetch bus + FIFO write bundle.
// master = fetch controller, slave = memory/FIFO side.
interface hsid_ref_fetch_ctrl_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int FIFO_CNT_WIDTH = 4
);
  logic                      bus_req;
  logic [ADDR_WIDTH-1:0]     bus_addr;
  logic                      bus_gnt;
  logic                      bus_rvalid;
  logic [WORD_WIDTH-1:0]     bus_rdata;
  logic [FIFO_CNT_WIDTH-1:0] fifo_ref_free;
  logic                      fifo_ref_wr_en;
  logic [WORD_WIDTH-1:0]     fifo_ref_data;

  modport master (
    output bus_req, bus_addr,
    output fifo_ref_wr_en, fifo_ref_data,
    input  bus_gnt, bus_rvalid, bus_rdata,
    input  fifo_ref_free
  );

  modport slave (
    input  bus_req, bus_addr,
    input  fifo_ref_wr_en, fifo_ref_data,
    output bus_gnt, bus_rvalid, bus_rdata,
    output fifo_ref_free
  );
endinterface

// File: rtl/hsid_ref_fetch_ctrl.sv
// Reference library fetch controller.
// Streams packed reference words from memory into the ref FIFO.
module hsid_ref_fetch_ctrl #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 8,
  parameter int HSP_LIBRARY_WIDTH = 8,
  parameter int ADDR_WIDTH        = 32,
  parameter int FIFO_CNT_WIDTH    = 4,
  parameter int MAX_OUT           = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
  hsid_ref_fetch_ctrl_if.master        bus,
  output logic [HSP_LIBRARY_WIDTH-1:0] ref_count,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         cancelled
);
  localparam int HB = HSP_BANDS_WIDTH;
  localparam int HL = HSP_LIBRARY_WIDTH;
  localparam int CW = HB + HL;
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    RF_IDLE, RF_CONFIG, RF_FETCH, RF_DRAIN,
    RF_DONE, RF_ERROR, RF_CLEAR
  } rf_state_t;

  rf_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_cfg_base;
  logic [HB-1:0]         r_cfg_bands;
  logic [HL-1:0]         r_cfg_lib;
  logic [HB-1:0]         r_packs;
  logic [CW-1:0]         r_total;
  logic [CW-1:0]         r_issued;
  logic [OW-1:0]         r_outst;
  logic [HB-1:0]         r_pack_cnt;
  logic [HL-1:0]         r_ref_count;
  logic                  r_bus_req;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic                  r_wr_en;
  logic [WORD_WIDTH-1:0] r_wr_data;
  logic                  r_done;
  logic                  r_error;
  logic                  r_cancelled;

  logic            w_req;
  logic            w_acc;
  logic            w_rv;
  logic            w_spur;
  logic            w_can_req;
  logic            w_cfg_bad;
  logic            w_last_pack;
  logic            w_to_idle;
  logic [HB:0]     w_b1;
  logic [HB-1:0]   w_packs;
  logic [CW-1:0]   w_total;
  logic [CW-1:0]   w_iss_nxt;
  logic [OW-1:0]   w_out_nxt;

  // Handshake, credit and job-shape decode.
  always_comb begin
    w_req     = r_bus_req & ~clear;
    w_acc     = w_req & bus.bus_gnt;
    w_rv      = bus.bus_rvalid & (r_outst != '0);
    w_spur    = bus.bus_rvalid & (r_outst == '0)
              & ((r_state == RF_FETCH)
              |  (r_state == RF_DRAIN));
    w_iss_nxt = r_issued + CW'(w_acc);
    w_out_nxt = r_outst + OW'(w_acc) - OW'(w_rv);
    w_can_req = (w_iss_nxt < r_total)
              && (int'(w_out_nxt) < MAX_OUT)
              && (int'(bus.fifo_ref_free)
                  > int'(w_out_nxt));
    w_b1      = {1'b0, r_cfg_bands} + (HB+1)'(1);
    w_packs   = w_b1[HB:1];
    w_total   = CW'(w_packs) * CW'(r_cfg_lib);
    w_cfg_bad = (r_cfg_bands < HB'(2))
              || (r_cfg_lib == '0);
    w_last_pack = (r_pack_cnt == r_packs - HB'(1));
    w_to_idle = !clear
              && ((r_state == RF_DONE)
              ||  (r_state == RF_ERROR)
              ||  ((r_state == RF_CLEAR)
                   && (r_outst == '0)));
  end

  // Job FSM with registered bus, FIFO and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RF_IDLE;
      r_cfg_base  <= '1;
      r_cfg_bands <= '1;
      r_cfg_lib   <= '1;
      r_packs     <= '0;
      r_total     <= '0;
      r_issued    <= '0;
      r_outst     <= '0;
      r_pack_cnt  <= '0;
      r_ref_count <= '0;
      r_bus_req   <= 1'b0;
      r_bus_addr  <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cancelled <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cancelled <= 1'b0;
      r_wr_en     <= 1'b0;
      r_outst     <= w_out_nxt;
      r_issued    <= w_iss_nxt;
      if (w_acc)
        r_bus_addr <= r_bus_addr
                    + ADDR_WIDTH'(WORD_WIDTH / 8);
      if (r_wr_en) begin
        if (w_last_pack) begin
          r_pack_cnt  <= '0;
          r_ref_count <= r_ref_count + HL'(1);
        end else begin
          r_pack_cnt <= r_pack_cnt + HB'(1);
        end
      end
      if (clear && (r_state != RF_IDLE)) begin
        r_state   <= RF_CLEAR;
        r_bus_req <= 1'b0;
      end else begin
        unique case (r_state)
          RF_IDLE: begin
            if (start) begin
              r_cfg_base  <= base_addr;
              r_cfg_bands <= hsp_bands;
              r_cfg_lib   <= hsp_library_size;
              r_state     <= RF_CONFIG;
            end
          end
          RF_CONFIG: begin
            r_packs    <= w_packs;
            r_total    <= w_total;
            r_bus_addr <= r_cfg_base;
            if (w_cfg_bad) begin
              r_state <= RF_ERROR;
              r_error <= 1'b1;
            end else begin
              r_state <= RF_FETCH;
            end
          end
          RF_FETCH: begin
            if (w_spur) begin
              r_state   <= RF_ERROR;
              r_error   <= 1'b1;
              r_bus_req <= 1'b0;
            end else begin
              if (w_rv) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= bus.bus_rdata;
              end
              if (w_iss_nxt == r_total) begin
                r_state   <= RF_DRAIN;
                r_bus_req <= 1'b0;
              end else if (!(r_bus_req && !w_acc)) begin
                r_bus_req <= w_can_req;
              end
            end
          end
          RF_DRAIN: begin
            if (w_spur) begin
              r_state <= RF_ERROR;
              r_error <= 1'b1;
            end else begin
              if (w_rv) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= bus.bus_rdata;
              end
              if (r_outst == '0) begin
                r_state <= RF_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          RF_CLEAR: begin
            if (r_outst == '0)
              r_cancelled <= 1'b1;
          end
          default: ;
        endcase
      end
      if (w_to_idle) begin
        r_state     <= RF_IDLE;
        r_cfg_base  <= '1;
        r_cfg_bands <= '1;
        r_cfg_lib   <= '1;
        r_packs     <= '0;
        r_total     <= '0;
        r_issued    <= '0;
        r_outst     <= '0;
        r_pack_cnt  <= '0;
        r_ref_count <= '0;
        r_bus_addr  <= '0;
      end
    end
  end

  assign bus.bus_req        = w_req;
  assign bus.bus_addr       = r_bus_addr;
  assign bus.fifo_ref_wr_en = r_wr_en;
  assign bus.fifo_ref_data  = r_wr_data;
  assign ref_count          = r_ref_count;
  assign busy               = (r_state != RF_IDLE);
  assign done               = r_done;
  assign error              = r_error;
  assign cancelled          = r_cancelled;
endmodule

// File: tb/tb_hsid_ref_fetch_ctrl.sv
// Bench for hsid_ref_fetch_ctrl: directed + random jobs
// against a memory/bus responder and job-level model.
module tb_hsid_ref_fetch_ctrl;
  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  hsp_bands;
  logic [7:0]  hsp_library_size;
  logic [7:0]  ref_count;
  logic        busy;
  logic        done;
  logic        error;
  logic        cancelled;

  hsid_ref_fetch_ctrl_if #(
    .WORD_WIDTH(32), .ADDR_WIDTH(32), .FIFO_CNT_WIDTH(4)
  ) bus_if ();

  hsid_ref_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .start(start), .base_addr(base_addr),
    .hsp_bands(hsp_bands),
    .hsp_library_size(hsp_library_size),
    .bus(bus_if), .ref_count(ref_count),
    .busy(busy), .done(done), .error(error),
    .cancelled(cancelled)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int cyc = 0, wr_cnt = 0, acc_cnt = 0, outst = 0;
  int max_out = 0, req_seen = 0, hold_cyc = 0;
  int drop_cnt = 0, lat = 2, gnt_pct = 100;
  int gnt_block = 0;
  bit chk_hold = 1, in_clear = 0, spur = 0;
  bit exp_wr = 0, held = 0, g;
  logic [31:0] job_base = 0, hold_addr = 0;
  int          due_q[$];
  logic [31:0] addr_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input logic [63:0] obs,
                     input logic [63:0] exp,
                     input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Memory/bus responder and per-cycle protocol checks.
  always @(negedge clk) begin
    cyc++;
    if (bus_if.fifo_ref_wr_en === 1'b1) begin
      chk(bus_if.fifo_ref_data,
          mem(job_base + 32'(4 * wr_cnt)), "fifo_data");
      wr_cnt++;
    end
    chk(bus_if.fifo_ref_wr_en, exp_wr, "wr_timing");
    exp_wr = 0;
    if (chk_hold && held) begin
      chk(bus_if.bus_req, 1, "req_hold");
      chk(bus_if.bus_addr, hold_addr, "addr_hold");
    end
    if (bus_if.bus_req === 1'b1) begin
      req_seen++;
      chk((outst < int'(bus_if.fifo_ref_free))
          && (outst < 2), 1, "credit");
    end
    if (gnt_block > 0) begin
      g = 0;
      if (bus_if.bus_req === 1'b1) gnt_block--;
    end else begin
      g = ($urandom_range(0, 99) < gnt_pct);
    end
    bus_if.bus_gnt = g;
    held = (bus_if.bus_req === 1'b1) && !g;
    hold_addr = bus_if.bus_addr;
    if (held) hold_cyc++;
    if ((bus_if.bus_req === 1'b1) && g) begin
      chk(bus_if.bus_addr,
          job_base + 32'(4 * acc_cnt), "req_addr");
      acc_cnt++;
      outst++;
      due_q.push_back(cyc + lat);
      addr_q.push_back(bus_if.bus_addr);
    end
    bus_if.bus_rvalid = 0;
    bus_if.bus_rdata  = $urandom;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      bus_if.bus_rvalid = 1;
      bus_if.bus_rdata  = mem(addr_q[0]);
      void'(due_q.pop_front());
      void'(addr_q.pop_front());
      outst--;
      if (in_clear) drop_cnt++;
      else exp_wr = 1;
    end else if (spur) begin
      bus_if.bus_rvalid = 1;
      spur = 0;
    end
    if (outst > max_out) max_out = outst;
  end

  task automatic begin_job(input int b, input int l,
                           input logic [31:0] base,
                           input int fr, input int lt,
                           input int pct);
    @(posedge clk); #1;
    job_base = base; lat = lt; gnt_pct = pct;
    bus_if.fifo_ref_free = 4'(fr);
    acc_cnt = 0; wr_cnt = 0; max_out = 0;
    req_seen = 0; hold_cyc = 0; drop_cnt = 0;
    hsp_bands = 8'(b); hsp_library_size = 8'(l);
    base_addr = base; start = 1;
    @(posedge clk); #1;
    start = 0;
    base_addr = $urandom;
    hsp_bands = 8'($urandom);
    hsp_library_size = 8'($urandom);
  endtask

  task automatic run_job(input int b, input int l,
                         input logic [31:0] base,
                         input int fr, input int lt,
                         input int pct, input string tag);
    int total, n;
    bit seen, ok;
    ok = (b >= 2) && (l != 0);
    total = ((b + 1) / 2) * l;
    begin_job(b, l, base, fr, lt, pct);
    n = 0; seen = 0;
    while (!seen && n < 2000) begin
      @(negedge clk); #1;
      n++;
      if (done || error || cancelled) seen = 1;
    end
    chk(seen, 1, {tag, "_finish"});
    if (ok) begin
      chk(done, 1, {tag, "_done"});
      chk({error, cancelled}, 0, {tag, "_excl"});
      chk(busy, 1, {tag, "_busy_done"});
      chk(ref_count, l, {tag, "_ref_count"});
      chk(acc_cnt, total, {tag, "_reqs"});
      chk(wr_cnt, total, {tag, "_writes"});
    end else begin
      chk(error, 1, {tag, "_error"});
      chk({done, cancelled}, 0, {tag, "_excl"});
      chk(req_seen, 0, {tag, "_no_req"});
    end
    @(negedge clk); #1;
    chk({done, error}, 0, {tag, "_one_cycle"});
    chk(busy, 0, {tag, "_idle"});
    chk(ref_count, 0, {tag, "_rc_idle"});
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 0; clear = 0; start = 0;
    base_addr = 0; hsp_bands = 0;
    hsp_library_size = 0;
    bus_if.fifo_ref_free = 4'd8;
    repeat (3) @(negedge clk);
    #1;
    chk(busy, 0, "rst_busy");
    chk(bus_if.bus_req, 0, "rst_req");
    chk(bus_if.bus_addr, 0, "rst_addr");
    chk(bus_if.fifo_ref_data, 0, "rst_fdata");
    chk(ref_count, 0, "rst_rc");
    chk({done, error, cancelled}, 0, "rst_flags");
    @(posedge clk); #1;
    rst_n = 1;

    run_job(4, 3, 32'h100, 8, 2, 100, "basic");

    run_job(4, 3, 32'h100, 1, 2, 100, "free1");
    chk(max_out, 1, "free1_max_out");

    run_job(1, 3, 32'h200, 8, 2, 100, "bands1");
    run_job(4, 0, 32'h200, 8, 2, 100, "lib0");

    gnt_block = 5;
    run_job(4, 3, 32'h2000, 8, 2, 100, "gnt_wait");
    chk(hold_cyc, 5, "gnt_wait_cycles");

    // abort with two reads in flight
    chk_hold = 0;
    begin_job(8, 4, 32'h3000, 8, 6, 100);
    n = 0;
    while (outst != 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk(outst, 2, "clr_two_out");
    @(posedge clk); #1;
    clear = 1; in_clear = 1;
    #1;
    chk(bus_if.bus_req, 0, "clr_req_low");
    @(posedge clk); #1;
    clear = 0;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk); #1;
      n++;
      if (cancelled) seen = 1;
    end
    chk(seen, 1, "clr_cancelled");
    chk({done, error}, 0, "clr_excl");
    chk(busy, 0, "clr_idle");
    chk(drop_cnt, 2, "clr_dropped");
    chk(wr_cnt, 0, "clr_no_write");
    @(negedge clk); #1;
    chk(cancelled, 0, "clr_one_cycle");
    in_clear = 0;

    // response with nothing outstanding
    gnt_block = 1000;
    begin_job(2, 1, 32'h4000, 8, 2, 100);
    n = 0;
    while (bus_if.bus_req !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk(bus_if.bus_req, 1, "spur_req_up");
    spur = 1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk); #1;
      n++;
      if (error) seen = 1;
    end
    chk(seen, 1, "spur_error");
    chk({done, cancelled}, 0, "spur_excl");
    chk(wr_cnt, 0, "spur_no_write");
    @(negedge clk); #1;
    chk(error, 0, "spur_one_cycle");
    chk(busy, 0, "spur_idle");
    gnt_block = 0; spur = 0;
    chk_hold = 1;

    for (int k = 0; k < 10; k++) begin
      run_job($urandom_range(2, 9),
              $urandom_range(1, 4),
              32'($urandom_range(0, 1023) * 4),
              $urandom_range(1, 8),
              $urandom_range(1, 4),
              $urandom_range(30, 100), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
